reg_writeback_unit: RTL and testbench

//  Write-side front end of the 2R1W integer register file. Accepts results from ALU and LSU via valid/ready.

---
 rtl/reg_wb_pkg.sv | 19 +
 rtl/reg_writeback_unit_fifo.sv | 59 +++++
 rtl/reg_writeback_unit.sv | 169 ++++++++++++++++
 tb/tb_reg_writeback_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// Shared widths, the pending-write entry type and the arbiter source encoding
// for the register write-back unit.
package reg_wb_pkg;

    localparam int INT32W       = 32;
    localparam int REGFILE_SIZE = 5;
    localparam int NUM_REGS     = 2 ** REGFILE_SIZE;

    typedef struct packed {
        logic [REGFILE_SIZE-1:0] rd;
        logic [INT32W-1:0]       data;
    } wb_entry_t;

    typedef enum logic {
        SRC_LSU = 1'b0,
        SRC_ALU = 1'b1
    } rr_src_e;

endpackage

// File: rtl/reg_writeback_unit_fifo.sv
// wb_fifo: pending-write buffer with up to two pushes and one pop per cycle.
// WB_FORWARD_EN additionally exposes every slot and its occupancy for forwarding.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push0,
    input  wb_entry_t  push0_entry,
    input  logic       push1,
    input  wb_entry_t  push1_entry,
    input  logic       pop,
    output wb_entry_t  head,
    output logic [CNT_W-1:0] count
`ifdef WB_FORWARD_EN
    ,
    output wb_entry_t  entries [FIFO_DEPTH],
    output logic [FIFO_DEPTH-1:0] entry_valid
`endif
);

    wb_entry_t mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // push1 is only ever raised together with push0, so it lands one slot later.
    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr] <= push0_entry;
        if (push1) mem[wr_ptr + PTR_W'(1)] <= push1_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
    end

    assign head = mem[rd_ptr];

`ifdef WB_FORWARD_EN
    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_view
        logic [PTR_W-1:0] offset;
        assign offset         = PTR_W'(i) - rd_ptr;
        assign entries[i]     = mem[i];
        assign entry_valid[i] = CNT_W'(offset) < count;
    end
`endif

endmodule

// File: rtl/reg_writeback_unit.sv
// Write-side front end of the 2R1W register file: ALU/LSU arbitration, pending
// FIFO, single write port and busy scoreboard. WB_FORWARD_EN adds operand forwarding.
module reg_writeback_unit
    import reg_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [REGFILE_SIZE-1:0] alu_rd,
    input  logic [INT32W-1:0]       alu_data,
    input  logic                    lsu_valid,
    output logic                    lsu_ready,
    input  logic [REGFILE_SIZE-1:0] lsu_rd,
    input  logic [INT32W-1:0]       lsu_data,
    input  logic                    claim_valid,
    input  logic [REGFILE_SIZE-1:0] claim_rd,
    output logic [NUM_REGS-1:0]     busy,
    output logic [REGFILE_SIZE-1:0] rd,
    output logic [INT32W-1:0]       dataRd
`ifdef WB_FORWARD_EN
    ,
    input  logic [REGFILE_SIZE-1:0] rs1,
    input  logic [REGFILE_SIZE-1:0] rs2,
    output logic                    fwd1_hit,
    output logic                    fwd2_hit,
    output logic [INT32W-1:0]       fwd1_data,
    output logic [INT32W-1:0]       fwd2_data
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Handshake: a result transfers on a cycle where valid && ready is seen at posedge clk;
    // ready is combinational from the valids, FIFO occupancy and RR pointer, and is 0 in reset.

    rr_src_e          rr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free;
    wb_entry_t        head, alu_e, lsu_e, pref_e, sec_e, out_e, push0_e, push1_e;
    logic             pop, alu_nz, lsu_nz, both_fit, acc_alu, acc_lsu;
    logic             pref_v, sec_v, out_v, push0, push1, rr_toggle;
    logic [NUM_REGS-1:0] busy_next;

    always_comb begin
        pop      = (count != '0);
        free     = CNT_W'(FIFO_DEPTH) - (count - CNT_W'(pop));
        alu_nz   = (alu_rd != '0);
        lsu_nz   = (lsu_rd != '0);
        // x0 results are dropped, so they need no slot.
        both_fit = free >= (CNT_W'(alu_nz) + CNT_W'(lsu_nz));
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (!rst) begin
            if (alu_valid && lsu_valid) begin
                alu_ready = both_fit || (rr == SRC_ALU);
                lsu_ready = both_fit || (rr == SRC_LSU);
            end else begin
                alu_ready = free >= CNT_W'(alu_nz);
                lsu_ready = free >= CNT_W'(lsu_nz);
            end
        end
        acc_alu   = alu_valid && alu_ready;
        acc_lsu   = lsu_valid && lsu_ready;
        rr_toggle = alu_valid && lsu_valid && (acc_alu != acc_lsu);

        alu_e.rd   = alu_rd;
        alu_e.data = alu_data;
        lsu_e.rd   = lsu_rd;
        lsu_e.data = lsu_data;
        if (rr == SRC_LSU) begin
            pref_e = lsu_e;  pref_v = acc_lsu && lsu_nz;
            sec_e  = alu_e;  sec_v  = acc_alu && alu_nz;
        end else begin
            pref_e = alu_e;  pref_v = acc_alu && alu_nz;
            sec_e  = lsu_e;  sec_v  = acc_lsu && lsu_nz;
        end

        // FIFO head always goes out first; with an empty FIFO the preferred input cuts through.
        if (pop) begin
            out_v   = 1'b1;
            out_e   = head;
            push0   = pref_v || sec_v;
            push0_e = pref_v ? pref_e : sec_e;
            push1   = pref_v && sec_v;
            push1_e = sec_e;
        end else begin
            out_v   = pref_v || sec_v;
            out_e   = pref_v ? pref_e : sec_e;
            push0   = pref_v && sec_v;
            push0_e = sec_e;
            push1   = 1'b0;
            push1_e = sec_e;
        end

        // Claim is applied after retire so a same-cycle claim keeps the bit set.
        busy_next = busy;
        if (out_v) busy_next[out_e.rd] = 1'b0;
        if (claim_valid) busy_next[claim_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd     <= '0;
            dataRd <= '0;
            rr     <= SRC_LSU;
            busy   <= '0;
        end else begin
            rd     <= out_v ? out_e.rd : '0;
            dataRd <= out_v ? out_e.data : '0;
            if (rr_toggle) rr <= (rr == SRC_LSU) ? SRC_ALU : SRC_LSU;
            busy   <= busy_next;
        end
    end

`ifdef WB_FORWARD_EN
    wb_entry_t             fifo_entries [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_entry_valid;
`endif

    wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push0       (push0),
        .push0_entry (push0_e),
        .push1       (push1),
        .push1_entry (push1_e),
        .pop         (pop),
        .head        (head),
        .count       (count)
`ifdef WB_FORWARD_EN
        ,
        .entries     (fifo_entries),
        .entry_valid (fifo_entry_valid)
`endif
    );

`ifdef WB_FORWARD_EN
    // Buffered entries are newer than the write-port register, so they take priority.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        if (rs1 != '0 && rd == rs1) begin
            fwd1_hit  = 1'b1;
            fwd1_data = dataRd;
        end
        if (rs2 != '0 && rd == rs2) begin
            fwd2_hit  = 1'b1;
            fwd2_data = dataRd;
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_entry_valid[i] && rs1 != '0 && fifo_entries[i].rd == rs1) begin
                fwd1_hit  = 1'b1;
                fwd1_data = fifo_entries[i].data;
            end
            if (fifo_entry_valid[i] && rs2 != '0 && fifo_entries[i].rd == rs2) begin
                fwd2_hit  = 1'b1;
                fwd2_data = fifo_entries[i].data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Bench for reg_writeback_unit: directed scenarios plus randomized traffic against a
// queue-based reference model; a monitor matches every emitted write to the expected queue.
module tb_reg_writeback_unit;
    import reg_wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int EW    = REGFILE_SIZE + INT32W;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    alu_valid, alu_ready, lsu_valid, lsu_ready, claim_valid;
    logic [REGFILE_SIZE-1:0] alu_rd, lsu_rd, claim_rd, rd;
    logic [INT32W-1:0]       alu_data, lsu_data, dataRd;
    logic [NUM_REGS-1:0]     busy;
`ifdef WB_FORWARD_EN
    logic [REGFILE_SIZE-1:0] rs1, rs2;
    logic                    fwd1_hit, fwd2_hit;
    logic [INT32W-1:0]       fwd1_data, fwd2_data;
`endif

    reg_writeback_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .claim_valid(claim_valid), .claim_rd(claim_rd),
        .busy(busy), .rd(rd), .dataRd(dataRd)
`ifdef WB_FORWARD_EN
        , .rs1(rs1), .rs2(rs2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0]       exp_q[$];   // writes the monitor must see, in order
    logic [EW-1:0]       mq[$];      // model: writes accepted but not yet on the write port
    logic [EW-1:0]       out_m;      // model: write currently on the write port
    logic [NUM_REGS-1:0] busy_m;
    bit                  rr_alu_m;   // model RR: 0 = LSU preferred
    bit                  exp_out_m;
    bit                  acc_a, acc_l, dut_ra, dut_rl;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every non-zero write index must match the oldest expected write.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (rd !== '0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected actual=%0h required=none", {rd, dataRd});
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_write", {rd, dataRd}, e);
                end
            end
        end
    end

`ifdef WB_FORWARD_EN
    function automatic logic [INT32W:0] fwd_model(input logic [REGFILE_SIZE-1:0] rs);
        if (rs == '0) return '0;
        foreach (mq[i]) if (mq[i][EW-1 -: REGFILE_SIZE] == rs) return {1'b1, mq[i][INT32W-1:0]};
        if (out_m[EW-1 -: REGFILE_SIZE] == rs) return {1'b1, out_m[INT32W-1:0]};
        return '0;
    endfunction
`endif

    // One clock cycle: drive, check state of the last edge, advance the model.
    task automatic step(input bit r,
                        input bit av, input logic [REGFILE_SIZE-1:0] ard, input logic [INT32W-1:0] ad,
                        input bit lv, input logic [REGFILE_SIZE-1:0] lrd, input logic [INT32W-1:0] ld,
                        input bit cv, input logic [REGFILE_SIZE-1:0] crd);
        int free, need;
        bit ra, rl;
        logic [EW-1:0] ea, el;
        rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld; claim_valid = cv; claim_rd = crd;
`ifdef WB_FORWARD_EN
        rs1 = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[0][EW-1 -: REGFILE_SIZE]
                                                         : REGFILE_SIZE'($urandom_range(0, NUM_REGS-1));
        rs2 = (out_m != '0 && $urandom_range(0, 1) == 1) ? out_m[EW-1 -: REGFILE_SIZE]
                                                        : REGFILE_SIZE'($urandom_range(0, 3));
`endif
        @(negedge clk);
        chk("busy", busy, busy_m);
        chk("out_present", rd != '0, exp_out_m);
`ifdef WB_FORWARD_EN
        chk("fwd1", {fwd1_hit, fwd1_data}, fwd_model(rs1));
        chk("fwd2", {fwd2_hit, fwd2_data}, fwd_model(rs2));
`endif
        ra = 0; rl = 0;
        if (!r) begin
            free = DEPTH - (mq.size() - ((mq.size() > 0) ? 1 : 0));
            if (av && lv) begin
                need = int'(ard != '0) + int'(lrd != '0);
                if (free >= need) begin ra = 1; rl = 1; end
                else begin ra = rr_alu_m; rl = !rr_alu_m; end
            end else begin
                ra = free >= int'(ard != '0);
                rl = free >= int'(lrd != '0);
            end
        end
        dut_ra = alu_ready; dut_rl = lsu_ready;
        if (av || r) chk("alu_ready", alu_ready, ra);
        if (lv || r) chk("lsu_ready", lsu_ready, rl);
        acc_a = av && ra;
        acc_l = lv && rl;
        if (r) begin
            mq.delete(); busy_m = '0; rr_alu_m = 0; exp_out_m = 0; out_m = '0;
        end else begin
            ea = {ard, ad};
            el = {lrd, ld};
            if (rr_alu_m) begin
                if (acc_a && ard != '0) begin mq.push_back(ea); exp_q.push_back(ea); end
                if (acc_l && lrd != '0) begin mq.push_back(el); exp_q.push_back(el); end
            end else begin
                if (acc_l && lrd != '0) begin mq.push_back(el); exp_q.push_back(el); end
                if (acc_a && ard != '0) begin mq.push_back(ea); exp_q.push_back(ea); end
            end
            if (av && lv && (acc_a != acc_l)) rr_alu_m = !rr_alu_m;
            exp_out_m = mq.size() > 0;
            out_m = exp_out_m ? mq.pop_front() : '0;
            if (exp_out_m) busy_m[out_m[EW-1 -: REGFILE_SIZE]] = 1'b0;
            if (cv && crd != '0) busy_m[crd] = 1'b1;
        end
        @(posedge clk);
        #1;
        if (r) exp_q.delete();
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, '0, '0, 0, '0);
    endtask

    // Destination that is not pending and differs from the other source's held result.
    function automatic logic [REGFILE_SIZE-1:0] pick_rd(input bit other_v, input logic [REGFILE_SIZE-1:0] other_rd);
        logic [REGFILE_SIZE-1:0] r;
        bit clash;
        if ($urandom_range(0, 9) == 0) return '0;
        for (int t = 0; t < 16; t++) begin
            r = REGFILE_SIZE'($urandom_range(1, NUM_REGS-1));
            clash = other_v && (other_rd == r);
            foreach (mq[i]) if (mq[i][EW-1 -: REGFILE_SIZE] == r) clash = 1;
            if (!clash) return r;
        end
        return '0;
    endfunction

    task automatic burst(input int n, input int rd_base, output bit saw_stall);
        logic [REGFILE_SIZE-1:0] aq[$], lq[$];
        int guard;
        saw_stall = 0;
        for (int i = 0; i < n; i++) begin
            aq.push_back(REGFILE_SIZE'(rd_base + 2 * i));
            lq.push_back(REGFILE_SIZE'(rd_base + 2 * i + 1));
        end
        guard = 0;
        while ((aq.size() > 0 || lq.size() > 0) && guard < 60) begin
            step(0, aq.size() > 0, (aq.size() > 0) ? aq[0] : '0, 32'hC0DE_0000 | 32'((aq.size() > 0) ? aq[0] : '0),
                    lq.size() > 0, (lq.size() > 0) ? lq[0] : '0, 32'hBEEF_0000 | 32'((lq.size() > 0) ? lq[0] : '0),
                    0, '0);
            if (aq.size() > 0 && lq.size() > 0 && !(dut_ra && dut_rl)) saw_stall = 1;
            if (acc_a) void'(aq.pop_front());
            if (acc_l) void'(lq.pop_front());
            guard++;
        end
        chk("burst_done", guard < 60, 1'b1);
    endtask

    initial begin
        bit stall, av_h, lv_h, cv;
        logic [REGFILE_SIZE-1:0] ard_h, lrd_h, crd;
        logic [INT32W-1:0] ad_h, ld_h;
        int pct, guard;

        rst = 1; alu_valid = 0; lsu_valid = 0; claim_valid = 0;
        alu_rd = '0; lsu_rd = '0; claim_rd = '0; alu_data = '0; lsu_data = '0;
`ifdef WB_FORWARD_EN
        rs1 = '0; rs2 = '0;
`endif
        busy_m = '0; rr_alu_m = 0; exp_out_m = 0; out_m = '0;
        @(posedge clk);
        #1;

        // Reset with ALU pushing, then first handshake after release
        step(1, 1, 5'd3, 32'h1111_1111, 0, '0, '0, 0, '0);
        step(1, 1, 5'd3, 32'h1111_1111, 0, '0, '0, 0, '0);
        chk("rst_rd", rd, '0);
        chk("rst_busy", busy, '0);
        step(0, 1, 5'd9, 32'hA5A5_0009, 0, '0, '0, 0, '0);
        chk("rst_first_rd", rd, 5'd9);

        // Single write retiring a claimed register
        step(0, 0, '0, '0, 0, '0, '0, 1, 5'd5);
        chk("claim5_busy", busy[5], 1'b1);
        step(0, 1, 5'd5, 32'hDEAD_BEEF, 0, '0, '0, 0, '0);
        chk("single_rd", rd, 5'd5);
        chk("single_data", dataRd, 32'hDEAD_BEEF);
        chk("single_busy5_clear", busy[5], 1'b0);
        idle();
        chk("single_after_rd", rd, '0);

        // x0 result is accepted but never written
        step(0, 0, '0, '0, 1, 5'd0, 32'h0000_1234, 0, '0);
        chk("x0_rd", rd, '0);

        // Claim and retire of x7 in the same cycle, then a claim of x0
        step(0, 1, 5'd7, 32'h0000_0077, 0, '0, '0, 1, 5'd7);
        chk("collide_rd", rd, 5'd7);
        chk("collide_busy7", busy[7], 1'b1);
        step(0, 0, '0, '0, 0, '0, '0, 1, 5'd0);
        chk("claim_x0", busy[0], 1'b0);

        // Dual burst: both sources every cycle, 1..8 then a longer one to force backpressure
        burst(4, 1, stall);
        repeat (6) idle();
        burst(8, 10, stall);
        chk("burst_backpressure", stall, 1'b1);
        repeat (10) idle();

        // Reset in the middle of a burst with busy registers outstanding
        step(0, 0, '0, '0, 0, '0, '0, 1, 5'd20);
        for (int i = 0; i < 4; i++)
            step(0, 1, REGFILE_SIZE'(2 + 2 * i), $urandom, 1, REGFILE_SIZE'(3 + 2 * i), $urandom, 1, REGFILE_SIZE'(21 + i));
        step(1, 1, 5'd12, 32'h0, 1, 5'd13, 32'h0, 0, '0);
        chk("midrst_rd", rd, '0);
        chk("midrst_busy", busy, '0);
        repeat (3) idle();

        // Randomized traffic at several load levels
        av_h = 0; lv_h = 0; ard_h = '0; lrd_h = '0; ad_h = '0; ld_h = '0;
        for (int ph = 0; ph < 3; ph++) begin
            pct = (ph == 0) ? 30 : (ph == 1) ? 70 : 100;
            for (int c = 0; c < 500; c++) begin
                if (!av_h && $urandom_range(0, 99) < pct) begin
                    av_h = 1; ard_h = pick_rd(lv_h, lrd_h); ad_h = $urandom;
                end
                if (!lv_h && $urandom_range(0, 99) < pct) begin
                    lv_h = 1; lrd_h = pick_rd(av_h, ard_h); ld_h = $urandom;
                end
                crd = REGFILE_SIZE'($urandom_range(0, NUM_REGS-1));
                cv  = ($urandom_range(0, 3) == 0) && !busy_m[crd];
                step(0, av_h, ard_h, ad_h, lv_h, lrd_h, ld_h, cv, crd);
                if (acc_a) av_h = 0;
                if (acc_l) lv_h = 0;
            end
        end

        guard = 0;
        while ((mq.size() > 0 || exp_out_m) && guard < 20) begin
            idle();
            guard++;
        end
        idle();
        chk("drain_exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
